// File: rtl/bcd_time_pkg.sv
// rtl/bcd_time_pkg.sv - shared types, limits and BCD field validation for bcd_time_counter
package bcd_time_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [7:0] FIELD_MAX     = 8'h59;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

    // Both digits must be decimal; a BCD-valid field then compares correctly as binary.
    function automatic logic bcd_field_valid(input logic [7:0] field, input logic [7:0] max_value);
        return (field[3:0] <= BCD_DIGIT_MAX) && (field[7:4] <= BCD_DIGIT_MAX) && (field <= max_value);
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// rtl/bcd_field_step.sv - one two-digit BCD field incrementer/decrementer with carry/borrow ripple
module bcd_field_step
    import bcd_time_pkg::*;
(
    input  logic [7:0] field,
    input  logic [7:0] field_max,
    input  logic       dir,
    input  logic       cin,
    output logic [7:0] next_field,
    output logic       cout
);

    logic [3:0] ones;
    logic [3:0] tens;

    assign ones = field[3:0];
    assign tens = field[7:4];

    always_comb begin
        next_field = field;
        cout       = 1'b0;
        if (cin) begin
            if (!dir) begin
                if (field == field_max) begin
                    next_field = 8'h00;
                    cout       = 1'b1;
                end else if (ones == BCD_DIGIT_MAX) begin
                    next_field = {tens + 4'd1, 4'd0};
                end else begin
                    next_field = {tens, ones + 4'd1};
                end
            end else begin
                if (field == 8'h00) begin
                    next_field = field_max;
                    cout       = 1'b1;
                end else if (ones == 4'd0) begin
                    next_field = {tens - 4'd1, BCD_DIGIT_MAX};
                end else begin
                    next_field = {tens, ones - 4'd1};
                end
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - parametrised multi-field BCD up/down timekeeper with load, alarm and expiry
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int         NUM_FIELDS = 2,
    parameter logic [7:0] TOP_MAX    = 8'h59,
    parameter bit         DOWN_STOP  = 1'b1,
    localparam int        WIDTH      = 8 * NUM_FIELDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             cmp_en,
    input  logic [WIDTH-1:0] cmp_value,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             carry,
    output logic             done,
    output logic             match,
    output logic             load_err
);

    state_t           state;
    logic [WIDTH-1:0] stepped;
    logic [NUM_FIELDS:0] chain;
    logic             wrap;
    logic             load_ok;
    logic             updated;

    assign chain[0] = 1'b1;
    assign wrap     = chain[NUM_FIELDS];
    assign running  = (state == RUNNING);

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        localparam logic [7:0] FMAX = (i == NUM_FIELDS - 1) ? TOP_MAX : FIELD_MAX;
        bcd_field_step u_step (
            .field      (count[8*i +: 8]),
            .field_max  (FMAX),
            .dir        (dir),
            .cin        (chain[i]),
            .next_field (stepped[8*i +: 8]),
            .cout       (chain[i+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!bcd_field_valid(load_value[8*i +: 8], (i == NUM_FIELDS - 1) ? TOP_MAX : FIELD_MAX)) begin
                load_ok = 1'b0;
            end
        end
    end

    // updated marks a tick-driven count change; match compares one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= STOPPED;
            count    <= '0;
            carry    <= 1'b0;
            done     <= 1'b0;
            match    <= 1'b0;
            load_err <= 1'b0;
            updated  <= 1'b0;
        end else begin
            carry    <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
            updated  <= 1'b0;
            match    <= updated && cmp_en && (count == cmp_value);
            if (load) begin
                if (load_ok) begin
                    count <= load_value;
                    if (state == EXPIRED) state <= STOPPED;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (stop) begin
                if (state == RUNNING) state <= STOPPED;
            end else if (start) begin
                if (state == STOPPED) state <= RUNNING;
            end else if (tick && state == RUNNING) begin
                if (dir && DOWN_STOP && count == '0) begin
                    done  <= 1'b1;
                    state <= EXPIRED;
                end else begin
                    count   <= stepped;
                    updated <= 1'b1;
                    if (dir && DOWN_STOP && stepped == '0) begin
                        done  <= 1'b1;
                        state <= EXPIRED;
                    end else begin
                        carry <= wrap;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter
module tb_bcd_time_counter;

    logic clk;
    int   checks;
    int   failures;

    // MM:SS instance with defaults
    logic        reset_a, tick_a, start_a, stop_a, dir_a, load_a, cmp_en_a;
    logic [15:0] load_value_a, cmp_value_a, count_a;
    logic        running_a, carry_a, done_a, match_a, load_err_a;

    // HH:MM:SS instance with wrapping countdown
    logic        reset_b, tick_b, start_b, stop_b, dir_b, load_b, cmp_en_b;
    logic [23:0] load_value_b, cmp_value_b, count_b;
    logic        running_b, carry_b, done_b, match_b, load_err_b;

    bcd_time_counter dut_a (
        .clk(clk), .reset(reset_a), .tick(tick_a), .start(start_a), .stop(stop_a),
        .dir(dir_a), .load(load_a), .load_value(load_value_a), .cmp_en(cmp_en_a),
        .cmp_value(cmp_value_a), .count(count_a), .running(running_a), .carry(carry_a),
        .done(done_a), .match(match_a), .load_err(load_err_a)
    );

    bcd_time_counter #(.NUM_FIELDS(3), .TOP_MAX(8'h23), .DOWN_STOP(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .tick(tick_b), .start(start_b), .stop(stop_b),
        .dir(dir_b), .load(load_b), .load_value(load_value_b), .cmp_en(cmp_en_b),
        .cmp_value(cmp_value_b), .count(count_b), .running(running_b), .carry(carry_b),
        .done(done_b), .match(match_b), .load_err(load_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc_a(input logic t, input logic st, input logic sp, input logic ld, input logic [15:0] lv);
        tick_a = t; start_a = st; stop_a = sp; load_a = ld; load_value_a = lv;
        @(negedge clk);
        tick_a = 1'b0; start_a = 1'b0; stop_a = 1'b0; load_a = 1'b0;
    endtask

    task automatic cyc_b(input logic t, input logic st, input logic ld, input logic [23:0] lv);
        tick_b = t; start_b = st; load_b = ld; load_value_b = lv;
        @(negedge clk);
        tick_b = 1'b0; start_b = 1'b0; load_b = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_a = 1'b1; tick_a = 0; start_a = 0; stop_a = 0; dir_a = 0; load_a = 0;
        load_value_a = '0; cmp_en_a = 0; cmp_value_a = '0;
        reset_b = 1'b1; tick_b = 0; start_b = 0; stop_b = 0; dir_b = 0; load_b = 0;
        load_value_b = '0; cmp_en_b = 0; cmp_value_b = '0;
        @(negedge clk); @(negedge clk);
        check("rst_count", count_a, 0);
        check("rst_running", running_a, 0);
        check("rst_pulses", {carry_a, done_a, match_a, load_err_a}, 0);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        // up wrap
        cyc_a(0, 0, 0, 1, 16'h5958);
        check("ld5958", count_a, 16'h5958);
        check("ld_stopped", running_a, 0);
        cyc_a(0, 1, 0, 0, '0);
        check("start_run", running_a, 1);
        cyc_a(1, 0, 0, 0, '0);
        check("up5959", count_a, 16'h5959);
        check("up5959_carry", carry_a, 0);
        cyc_a(1, 0, 0, 0, '0);
        check("wrap0000", count_a, 16'h0000);
        check("wrap_carry", carry_a, 1);
        cyc_a(0, 0, 0, 0, '0);
        check("carry_clear", carry_a, 0);

        // digit/field carry and stop-beats-tick
        cyc_a(0, 0, 0, 1, 16'h0959);
        check("ld_keeps_run", running_a, 1);
        cyc_a(1, 0, 0, 0, '0);
        check("ripple1000", count_a, 16'h1000);
        cyc_a(1, 0, 1, 0, '0);
        check("stop_tick_cnt", count_a, 16'h1000);
        check("stop_tick_run", running_a, 0);

        // countdown with expiry
        dir_a = 1'b1;
        cyc_a(0, 0, 0, 1, 16'h0002);
        cyc_a(0, 1, 0, 0, '0);
        cyc_a(1, 0, 0, 0, '0);
        check("dn0001", count_a, 16'h0001);
        check("dn0001_done", done_a, 0);
        cyc_a(1, 0, 0, 0, '0);
        check("dn0000", count_a, 16'h0000);
        check("dn_done", done_a, 1);
        check("dn_expired", running_a, 0);
        cyc_a(0, 0, 0, 0, '0);
        check("done_clear", done_a, 0);
        cyc_a(1, 0, 0, 0, '0);
        check("exp_tick_cnt", count_a, 16'h0000);
        check("exp_tick_done", done_a, 0);
        cyc_a(0, 1, 0, 0, '0);
        check("exp_start_ign", running_a, 0);
        cyc_a(0, 0, 0, 1, 16'h0010);
        check("exp_ld0010", count_a, 16'h0010);
        cyc_a(0, 1, 0, 0, '0);
        check("stopped_start", running_a, 1);
        cyc_a(0, 0, 1, 0, '0);
        cyc_a(0, 0, 0, 1, 16'h0000);
        cyc_a(0, 1, 0, 0, '0);
        cyc_a(1, 0, 0, 0, '0);
        check("zero_tick_cnt", count_a, 16'h0000);
        check("zero_tick_done", done_a, 1);
        check("zero_tick_exp", running_a, 0);
        cyc_a(0, 0, 0, 1, 16'h0000);

        // invalid loads
        cyc_a(0, 0, 0, 1, 16'h0A60);
        check("err_0a60", load_err_a, 1);
        check("err_0a60_cnt", count_a, 16'h0000);
        cyc_a(0, 0, 0, 0, '0);
        check("err_clear", load_err_a, 0);
        cyc_a(0, 0, 0, 1, 16'h6000);
        check("err_6000", load_err_a, 1);
        cyc_a(0, 0, 0, 1, 16'h0070);
        check("err_0070", load_err_a, 1);
        cyc_a(0, 0, 0, 1, 16'h5959);
        check("ok_5959_err", load_err_a, 0);
        check("ok_5959_cnt", count_a, 16'h5959);

        // alarm match
        dir_a = 1'b0; cmp_en_a = 1'b1; cmp_value_a = 16'h0005;
        cyc_a(0, 0, 0, 1, 16'h0003);
        cyc_a(0, 1, 0, 0, '0);
        cyc_a(1, 0, 0, 0, '0);
        check("m0004", match_a, 0);
        cyc_a(0, 0, 0, 0, '0);
        check("m0004_next", match_a, 0);
        cyc_a(1, 0, 0, 0, '0);
        check("m0005_cnt", count_a, 16'h0005);
        check("m0005_same", match_a, 0);
        cyc_a(0, 0, 0, 0, '0);
        check("m0005_next", match_a, 1);
        cyc_a(0, 0, 0, 0, '0);
        check("m_pulse_end", match_a, 0);
        cyc_a(0, 0, 1, 0, '0);
        cyc_a(0, 0, 0, 1, 16'h0005);
        cyc_a(0, 0, 0, 0, '0);
        check("m_load_a", match_a, 0);
        cyc_a(0, 0, 0, 0, '0);
        check("m_load_b", match_a, 0);

        // HH:MM:SS wrap both ways and async reset
        cyc_b(0, 0, 1, 24'h235959);
        check("b_ld", count_b, 24'h235959);
        cyc_b(0, 1, 0, '0);
        cyc_b(1, 0, 0, '0);
        check("b_wrap", count_b, 24'h000000);
        check("b_wrap_carry", carry_b, 1);
        dir_b = 1'b1;
        cyc_b(1, 0, 0, '0);
        check("b_dnwrap", count_b, 24'h235959);
        check("b_dnwrap_carry", carry_b, 1);
        check("b_dnwrap_done", done_b, 0);
        cyc_b(1, 0, 0, '0);
        check("b_dn235958", count_b, 24'h235958);
        check("b_dn_nocarry", carry_b, 0);
        #2 reset_b = 1'b1;
        #1;
        check("b_async_cnt", count_b, 0);
        check("b_async_run", running_b, 0);
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        check("b_post_rst", count_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Parametrised BCD timekeeper for the clock/alarm/timer services. Successor to the fixed MM:SS counter.
- Supports N two-digit BCD fields (MM:SS, HH:MM:SS, ...) and an up/down direction.
- Adds start/stop control, countdown expiry, a validated parallel load and a compare-match pulse for alarms.
- Sits between the 1 Hz tick divider and the display/anode mux. Its count feeds set_anode-style display logic.

Parameters:
- NUM_FIELDS, 2, number of two-digit BCD fields; WIDTH = 8*NUM_FIELDS. Field 0 is the least significant (seconds).
- TOP_MAX, 8'h59, BCD maximum of the most significant field (8'h59 for minutes, 8'h23 for hours). Lower fields are always max 8'h59.
- DOWN_STOP, 1, 1 = down count stops at zero and expires; 0 = down count wraps to the maximum value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle count enable (1 Hz strobe)
- start  in  1  pulse: begin counting
- stop  in  1  pulse: halt counting
- dir  in  1  0 = up, 1 = down; sampled on every tick
- load  in  1  pulse: load load_value
- load_value  in  WIDTH  BCD value to load
- cmp_en  in  1  enable compare
- cmp_value  in  WIDTH  BCD compare value (alarm time)
- count  out  WIDTH  current BCD count
- running  out  1  high in RUNNING state
- carry  out  1  1-cycle pulse on wrap (up: max->0; down with DOWN_STOP=0: 0->max)
- done  out  1  1-cycle pulse on countdown expiry
- match  out  1  1-cycle pulse when a tick-driven update makes count == cmp_value
- load_err  out  1  1-cycle pulse when a load is rejected

Behaviour:
- Reset (async, any time, including mid-count): count=0, state=STOPPED, all pulse outputs 0.
- States and transitions:
  - STOPPED: start -> RUNNING.
  - RUNNING: stop -> STOPPED; expiry -> EXPIRED.
  - EXPIRED: start is ignored; a valid load -> STOPPED.
- Same-cycle priority: load > stop > start > tick.
  - A tick coinciding with load, stop or start is dropped.
  - Load does not change RUNNING or STOPPED.
- Tick is acted on only in RUNNING. Count updates on the clock edge where tick=1. Latency: 1 cycle from tick to the new count.
- Up step, per field from field 0, with carry ripple:
  - ones 9 -> 0 with carry into tens.
  - Field at its max -> 00 with carry into the next field.
  - Top field at TOP_MAX -> 00 and carry pulses.
  - Example: x959 -> (x+1)000.
- Down step, with borrow ripple:
  - ones 0 -> 9 with borrow from tens.
  - Lower field 00 -> 59 with borrow from the next field.
  - Top field 00 -> TOP_MAX: DOWN_STOP=0 wraps and pulses carry.
- DOWN_STOP=1:
  - A decrement that produces all-zero pulses done in the same cycle and enters EXPIRED.
  - A tick while RUNNING with count already 0 and dir=1: count unchanged, done pulses, enters EXPIRED.
- Load validation:
  - Every digit ≤ 9; tens of lower fields ≤ 5; top field ≤ TOP_MAX.
  - Invalid: count unchanged, state unchanged, load_err pulses on the next cycle.
  - Valid: count = load_value on the next edge.
- Match:
  - Registered; asserted for 1 cycle, the cycle after the tick-driven update that makes count == cmp_value with cmp_en=1.
  - Loads never raise match.
  - A dropped tick never raises match.
- Pulse outputs are registered and never held for more than 1 cycle.

Decomposition:
- Package bcd_time_pkg:
  - state enum {STOPPED, RUNNING, EXPIRED}
  - constants FIELD_MAX = 8'h59 and BCD_DIGIT_MAX = 4'h9
  - function bcd_field_valid(field, max)
- One combinational sub-module bcd_field_step:
  - Inputs: 8-bit field, field max, dir, carry/borrow in.
  - Outputs: next field, carry/borrow out.
  - Instantiated NUM_FIELDS times in a generate loop, with the top instance given TOP_MAX.

Test Plan:
- Up wrap (defaults): load 16'h5958, start, 2 ticks -> count 5959 then 0000; carry pulses exactly on the second update.
- Digit/field carry: load 16'h0959, start, tick -> 1000; a tick on the same cycle as stop -> count stays 1000, running=0.
- Countdown (DOWN_STOP=1, dir=1): load 16'h0002, start, 3 ticks -> 0001, 0000 with done pulse and EXPIRED; third tick gives no change; start ignored; load 16'h0010 -> STOPPED.
- Invalid load: load 16'h0A60 -> load_err 1-cycle pulse, count unchanged; load 16'h6000 (above TOP_MAX=8'h59) -> load_err.
- Alarm match: cmp_en=1, cmp_value 16'h0005; load 0003, start, ticks -> match high exactly one cycle after count becomes 0005; load 0005 directly -> no match.
- HH:MM:SS (NUM_FIELDS=3, TOP_MAX=8'h23): load 24'h235959, tick -> 000000 with carry; assert reset mid-run -> count 0, running=0 immediately (asynchronous).
